// File: rtl/stream_upsize_out_slice.sv
// Registered output slice for the upsize path.
// Holds up to two wide beats (main + skid) so that s_ready_o is a flop and
// the sink's m_ready_i never reaches the upsizer combinationally.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | no beat held; m_valid_o=0, s_ready_o=1 (0 right after reset)
// ONE   | main holds a beat; m_valid_o=1, s_ready_o=1
// FULL  | main and skid both hold beats; m_valid_o=1, s_ready_o=0
module stream_upsize_out_slice #(
  parameter int T_DATA_WIDTH = 1,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
  output logic [T_DATA_RATIO-1:0] m_keep_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    err_keep_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]              state_q;
  logic [1:0]              state_nxt;
  logic                    s_ready_q;
  logic                    m_valid_q;
  logic                    err_keep_q;

  logic [T_DATA_WIDTH-1:0] main_data_q [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] main_keep_q;
  logic                    main_last_q;

  logic [T_DATA_WIDTH-1:0] skid_data_q [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] skid_keep_q;
  logic                    skid_last_q;

  logic                    acc;
  logic                    pop;
  logic                    load_main_in;
  logic                    load_main_skid;
  logic                    load_skid;

  assign acc = s_valid_i & s_ready_q;
  assign pop = m_valid_q & m_ready_i;

  // Next state and which register gets loaded from where.
  always_comb begin
    state_nxt      = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State plus the two handshake flops, derived from the next state so they
  // are pure register outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_EMPTY;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      m_valid_q <= (state_nxt != ST_EMPTY);
      s_ready_q <= (state_nxt != ST_FULL);
    end
  end

  // Main register: drives m_*; refilled from the input or from the skid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        main_data_q[i] <= '0;
      end
      main_keep_q <= '0;
      main_last_q <= 1'b0;
    end else if (load_main_in) begin
      main_data_q <= s_data_i;
      main_keep_q <= s_keep_i;
      main_last_q <= s_last_i;
    end else if (load_main_skid) begin
      main_data_q <= skid_data_q;
      main_keep_q <= skid_keep_q;
      main_last_q <= skid_last_q;
    end
  end

  // Skid register: catches the beat accepted while the sink stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        skid_data_q[i] <= '0;
      end
      skid_keep_q <= '0;
      skid_last_q <= 1'b0;
    end else if (load_skid) begin
      skid_data_q <= s_data_i;
      skid_keep_q <= s_keep_i;
      skid_last_q <= s_last_i;
    end
  end

  // Sticky flag for an accepted beat with no valid lanes; the beat still passes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_keep_q <= 1'b0;
    end else if (acc && (s_keep_i == '0)) begin
      err_keep_q <= 1'b1;
    end
  end

  assign s_ready_o  = s_ready_q;
  assign m_valid_o  = m_valid_q;
  assign m_data_o   = main_data_q;
  assign m_keep_o   = main_keep_q;
  assign m_last_o   = main_last_q;
  assign err_keep_o = err_keep_q;

endmodule
